// File: rtl/prg_bus_arb_if.sv
// Bus bundle for the PRG memory arbiter: CPU side, MCU host channel and physical memory port.
// The arbiter uses the slave modport; the surrounding logic (or bench) uses master.
interface prg_bus_arb_if;
    logic        m2;
    logic [22:0] cpu_addr;
    logic        cpu_ce;
    logic        cpu_rw;
    logic [7:0]  cpu_wdat;
    logic [7:0]  cpu_rdat;
    logic        host_req;
    logic        host_we;
    logic [22:0] host_addr;
    logic [7:0]  host_wdat;
    logic        host_ack;
    logic [7:0]  host_rdat;
    logic [22:0] mem_addr;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdat;
    logic [7:0]  mem_rdat;

    modport slave (
        input  m2, cpu_addr, cpu_ce, cpu_rw, cpu_wdat,
        input  host_req, host_we, host_addr, host_wdat,
        input  mem_rdat,
        output cpu_rdat, host_ack, host_rdat,
        output mem_addr, mem_oe, mem_we, mem_wdat
    );

    modport master (
        output m2, cpu_addr, cpu_ce, cpu_rw, cpu_wdat,
        output host_req, host_we, host_addr, host_wdat,
        output mem_rdat,
        input  cpu_rdat, host_ack, host_rdat,
        input  mem_addr, mem_oe, mem_we, mem_wdat
    );
endinterface

// File: rtl/prg_bus_arb.sv
// PRG memory port arbiter: CPU fetches own the M2 phase, host accesses fill the slack.
// Define PRG_ARB_HOST_WR_EN to let host writes assert mem_we; otherwise host writes run as reads.
module prg_bus_arb #(
    parameter int MEM_WAIT = 3,
    parameter int IDLE_TO  = 64
) (
    input  logic          clk,
    input  logic          rst,
    prg_bus_arb_if.slave  bus
);

`ifdef PRG_ARB_HOST_WR_EN
    localparam bit HOST_WR_EN = 1'b1;
`else
    localparam bit HOST_WR_EN = 1'b0;
`endif

    localparam int          IW       = $clog2(IDLE_TO + 1);
    localparam logic [2:0]  WAIT_END = 3'(MEM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, CPU_ACC, HOST_ACC, HOST_ACK} state_t;

    state_t      state_q, state_d;
    logic [1:0]  m2_sync_q, m2_sync_d;
    logic        m2_prev_q, m2_prev_d;
    logic [2:0]  wait_q, wait_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic        slot_open_q, slot_open_d;
    logic        cpu_pend_q, cpu_pend_d;
    logic [22:0] haddr_q, haddr_d;
    logic [7:0]  hwdat_q, hwdat_d;
    logic        hwe_q, hwe_d;
    logic [7:0]  cpu_rdat_q, cpu_rdat_d;
    logic [7:0]  host_rdat_q, host_rdat_d;

    logic        m2_rise, last_cyc, bus_idle, cpu_go, host_wr;
    logic [22:0] mem_addr;
    logic        mem_oe, mem_we;
    logic [7:0]  mem_wdat;

    assign m2_rise  = m2_sync_q[1] & ~m2_prev_q;
    assign last_cyc = (wait_q == WAIT_END);
    assign bus_idle = (idle_cnt_q == IW'(IDLE_TO));
    assign cpu_go   = cpu_pend_q | (m2_rise & bus.cpu_ce);
    assign host_wr  = hwe_q & HOST_WR_EN;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        m2_sync_d   = {m2_sync_q[0], bus.m2};
        m2_prev_d   = m2_sync_q[1];
        wait_d      = wait_q;
        haddr_d     = haddr_q;
        hwdat_d     = hwdat_q;
        hwe_d       = hwe_q;
        cpu_rdat_d  = cpu_rdat_q;
        host_rdat_d = host_rdat_q;
        cpu_pend_d  = cpu_pend_q | (m2_rise & bus.cpu_ce);
        mem_addr    = '0;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;
        mem_wdat    = '0;

        if (m2_rise)       idle_cnt_d = '0;
        else if (bus_idle) idle_cnt_d = idle_cnt_q;
        else               idle_cnt_d = idle_cnt_q + IW'(1);

        // An M2 rise decides the slot; otherwise an idle bus keeps it open for back-to-back host use.
        if (m2_rise)                              slot_open_d = ~bus.cpu_ce;
        else if (bus_idle)                        slot_open_d = 1'b1;
        else if (state_q == CPU_ACC && last_cyc)  slot_open_d = 1'b1;
        else if (state_q == HOST_ACK)             slot_open_d = 1'b0;
        else                                      slot_open_d = slot_open_q;

        case (state_q)
            IDLE: begin
                if (cpu_go) begin
                    state_d    = CPU_ACC;
                    wait_d     = '0;
                    cpu_pend_d = 1'b0;
                end else if (bus.host_req && slot_open_q) begin
                    state_d = HOST_ACC;
                    wait_d  = '0;
                    haddr_d = bus.host_addr;
                    hwdat_d = bus.host_wdat;
                    hwe_d   = bus.host_we;
                end
            end
            CPU_ACC: begin
                mem_addr = bus.cpu_addr;
                mem_oe   = bus.cpu_rw;
                mem_we   = ~bus.cpu_rw;
                mem_wdat = bus.cpu_wdat;
                if (last_cyc) begin
                    if (bus.cpu_rw) cpu_rdat_d = bus.mem_rdat;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            HOST_ACC: begin
                mem_addr = haddr_q;
                mem_oe   = ~host_wr;
                mem_we   = host_wr;
                mem_wdat = hwdat_q;
                if (last_cyc) begin
                    if (!host_wr) host_rdat_d = bus.mem_rdat;
                    state_d = HOST_ACK;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            HOST_ACK: begin
                // A CPU cycle that arrived during the host access starts right after the ack.
                if (cpu_go) begin
                    state_d    = CPU_ACC;
                    wait_d     = '0;
                    cpu_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= IDLE;
            m2_sync_q   <= '0;
            m2_prev_q   <= 1'b0;
            wait_q      <= '0;
            idle_cnt_q  <= '0;
            slot_open_q <= 1'b0;
            cpu_pend_q  <= 1'b0;
            haddr_q     <= '0;
            hwdat_q     <= '0;
            hwe_q       <= 1'b0;
            cpu_rdat_q  <= '0;
            host_rdat_q <= '0;
        end else begin
            state_q     <= state_d;
            m2_sync_q   <= m2_sync_d;
            m2_prev_q   <= m2_prev_d;
            wait_q      <= wait_d;
            idle_cnt_q  <= idle_cnt_d;
            slot_open_q <= slot_open_d;
            cpu_pend_q  <= cpu_pend_d;
            haddr_q     <= haddr_d;
            hwdat_q     <= hwdat_d;
            hwe_q       <= hwe_d;
            cpu_rdat_q  <= cpu_rdat_d;
            host_rdat_q <= host_rdat_d;
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_oe    = mem_oe;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdat  = mem_wdat;
    assign bus.cpu_rdat  = cpu_rdat_q;
    assign bus.host_rdat = host_rdat_q;
    assign bus.host_ack  = (state_q == HOST_ACK);

endmodule

// File: tb/tb_prg_bus_arb.sv
// Directed bench for prg_bus_arb (MEM_WAIT=3, IDLE_TO=64); memory model returns addr[7:0]^addr[15:8]^0x87.
// Expectations follow PRG_ARB_HOST_WR_EN when it is defined for the build.
module tb_prg_bus_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    prg_bus_arb_if bus ();

    prg_bus_arb #(.MEM_WAIT(3), .IDLE_TO(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdat = bus.mem_addr[7:0] ^ bus.mem_addr[15:8] ^ 8'h87;

`ifdef PRG_ARB_HOST_WR_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    localparam logic [22:0] CPU_A3 = 23'h000100;

    // Bus monitor: strobe overlap, back-to-back strobes without gap, ordering, ack count.
    int   cpu_starts = 0, host_starts = 0, acks = 0, overlaps = 0, order_err = 0;
    logic strobe_prev = 1'b0;
    logic [22:0] addr_prev = '0;
    bit   last_was_cpu = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_oe && bus.mem_we) overlaps++;
        if (bus.host_ack) acks++;
        if ((bus.mem_oe || bus.mem_we) && strobe_prev && bus.mem_addr != addr_prev) overlaps++;
        if ((bus.mem_oe || bus.mem_we) && !strobe_prev) begin
            if (bus.mem_addr == CPU_A3) begin
                cpu_starts++;
                last_was_cpu = 1'b1;
            end else begin
                host_starts++;
                if (!last_was_cpu) order_err++;
                last_was_cpu = 1'b0;
            end
        end
        strobe_prev = bus.mem_oe || bus.mem_we;
        addr_prev   = bus.mem_addr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int s_cpu, s_host, s_ack, s_ovl, s_ord, a0;

        bus.m2 = 1'b0; bus.cpu_addr = '0; bus.cpu_ce = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_wdat = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdat = '0;

        // Reset values
        repeat (3) cyc();
        chk("rst_oe", bus.mem_oe, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdat", bus.mem_wdat, 0);
        chk("rst_cpu_rdat", bus.cpu_rdat, 0);
        chk("rst_ack", bus.host_ack, 0);
        chk("rst_host_rdat", bus.host_rdat, 0);
        rst = 1'b0;
        cyc();

        // CPU read 0x0123: strobes 3..5 clk after M2 rise, data 0xA5
        a0 = acks;
        bus.cpu_addr = 23'h000123; bus.cpu_ce = 1'b1; bus.cpu_rw = 1'b1; bus.m2 = 1'b1;
        cyc(); cyc();
        chk("cpu_oe_c2", bus.mem_oe, 0);
        cyc();
        chk("cpu_oe_c3", bus.mem_oe, 1);
        chk("cpu_addr_c3", bus.mem_addr, 23'h000123);
        chk("cpu_we_c3", bus.mem_we, 0);
        cyc();
        chk("cpu_oe_c4", bus.mem_oe, 1);
        cyc();
        chk("cpu_oe_c5", bus.mem_oe, 1);
        chk("cpu_rdat_c5", bus.cpu_rdat, 0);
        cyc();
        chk("cpu_oe_c6", bus.mem_oe, 0);
        chk("cpu_rdat_c6", bus.cpu_rdat, 8'hA5);
        chk("cpu_no_ack", acks - a0, 0);
        bus.m2 = 1'b0;

        // Host reads on an idle bus, back to back
        repeat (70) cyc();
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 23'h004000;
        cyc();
        chk("h1_oe", bus.mem_oe, 1);
        chk("h1_addr", bus.mem_addr, 23'h004000);
        chk("h1_ack_early", bus.host_ack, 0);
        cyc(); cyc();
        chk("h1_oe_c3", bus.mem_oe, 1);
        cyc();
        chk("h1_ack", bus.host_ack, 1);
        chk("h1_rdat", bus.host_rdat, 8'hC7);
        chk("h1_oe_gap", bus.mem_oe, 0);
        bus.host_addr = 23'h004001;
        cyc();
        chk("h2_ack_low", bus.host_ack, 0);
        chk("h2_gap", bus.mem_oe, 0);
        cyc();
        chk("h2_oe", bus.mem_oe, 1);
        chk("h2_addr", bus.mem_addr, 23'h004001);
        cyc(); cyc(); cyc();
        chk("h2_ack", bus.host_ack, 1);
        chk("h2_rdat", bus.host_rdat, 8'hC6);
        bus.host_req = 1'b0;
        cyc();

        // M2 rise while a host access is in flight
        bus.cpu_addr = 23'h000240; bus.cpu_ce = 1'b1; bus.cpu_rw = 1'b1;
        bus.host_req = 1'b1; bus.host_addr = 23'h004000;
        cyc();
        chk("mid_h_oe", bus.mem_oe, 1);
        chk("mid_h_addr", bus.mem_addr, 23'h004000);
        bus.m2 = 1'b1;
        cyc(); cyc(); cyc();
        chk("mid_ack", bus.host_ack, 1);
        chk("mid_h_rdat", bus.host_rdat, 8'hC7);
        chk("mid_ack_gap", bus.mem_oe, 0);
        bus.host_req = 1'b0;
        cyc();
        chk("mid_cpu_oe", bus.mem_oe, 1);
        chk("mid_cpu_addr", bus.mem_addr, 23'h000240);
        chk("mid_ack_once", bus.host_ack, 0);
        cyc(); cyc(); cyc();
        chk("mid_cpu_done", bus.mem_oe, 0);
        chk("mid_cpu_rdat", bus.cpu_rdat, 8'hC5);
        bus.m2 = 1'b0;
        repeat (6) cyc();

        // Active CPU (M2 period 12 clk) with host request held
        bus.cpu_addr = CPU_A3; bus.host_req = 1'b1; bus.host_addr = 23'h004000;
        for (int p = 0; p < 6; p++) begin
            if (p == 2) begin
                s_cpu = cpu_starts; s_host = host_starts; s_ack = acks;
                s_ovl = overlaps; s_ord = order_err;
            end
            bus.m2 = 1'b1;
            repeat (6) cyc();
            bus.m2 = 1'b0;
            repeat (6) cyc();
        end
        chk("act_cpu_cnt", cpu_starts - s_cpu, 4);
        chk("act_host_cnt", host_starts - s_host, 4);
        chk("act_ack_cnt", acks - s_ack, 4);
        chk("act_overlap", overlaps - s_ovl, 0);
        chk("act_order", order_err - s_ord, 0);
        chk("act_cpu_rdat", bus.cpu_rdat, 8'h86);
        bus.host_req = 1'b0;
        chk("all_overlap", overlaps, 0);

        // Host write 0x5A to 0x6010
        repeat (70) cyc();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 23'h006010; bus.host_wdat = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wr_we", bus.mem_we, WR_EN);
            chk("wr_oe", bus.mem_oe, !WR_EN);
            chk("wr_addr", bus.mem_addr, 23'h006010);
            if (WR_EN) chk("wr_wdat", bus.mem_wdat, 8'h5A);
        end
        cyc();
        chk("wr_ack", bus.host_ack, 1);
        chk("wr_we_off", bus.mem_we, 0);
        chk("wr_host_rdat", bus.host_rdat, WR_EN ? 8'hC7 : 8'hF7);
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        repeat (3) cyc();

        // Reset in the middle of a CPU access
        bus.cpu_addr = 23'h000123; bus.cpu_ce = 1'b1; bus.cpu_rw = 1'b1; bus.m2 = 1'b1;
        cyc(); cyc(); cyc();
        chk("rmid_oe_pre", bus.mem_oe, 1);
        rst = 1'b1; bus.m2 = 1'b0;
        cyc();
        chk("rmid_oe", bus.mem_oe, 0);
        chk("rmid_we", bus.mem_we, 0);
        chk("rmid_addr", bus.mem_addr, 0);
        chk("rmid_state", dut.state_q, 2'b00);
        chk("rmid_cpu_rdat", bus.cpu_rdat, 0);
        chk("rmid_ack", bus.host_ack, 0);
        rst = 1'b0;
        repeat (4) cyc();
        chk("rmid_quiet", bus.mem_oe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
